// File: rtl/carpma_seq.sv
// Sequential unsigned shift-and-add multiplier.
// One multiplier bit per cycle; result and done held until next start.
module carpma_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               done
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   product_q, product_d;
  logic            done_q, done_d;
  logic [PW-1:0]   addend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign addend = mplier_q[0] ? mcand_q : '0;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = done_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, multiplicand};
          mplier_d = multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          done_d   = 1'b0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_q + addend;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // last iteration publishes the sum including its own add
        if (cnt_q == LAST) begin
          product_d = acc_q + addend;
          done_d    = 1'b1;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;
  assign done    = done_q;

endmodule

// File: tb/tb_carpma_seq.sv
// Self-checking bench for carpma_seq (WIDTH=4).
// Directed and random multiplies against an arithmetic reference.
module tb_carpma_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic [7:0] product;
  logic       done;

  int total = 0;
  int bad   = 0;
  logic [7:0] prev;

  carpma_seq #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start is raised now and sampled at the next rising edge (T0).
  task automatic mul(input logic [3:0] a, input logic [3:0] b,
                     input bit noise);
    logic [7:0] exp;
    exp = 8'(a) * 8'(b);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept_done", 16'(done), 16'd0);
    chk("accept_prod", 16'(product), 16'(prev));
    for (int k = 1; k <= 4; k++) begin
      if (noise) begin
        multiplicand = 4'($urandom);
        multiplier   = 4'($urandom);
        start        = (k <= 2) ? 1'($urandom) : 1'b0;
      end
      @(posedge clk);
      #1;
      if (k < 4) begin
        chk("calc_done", 16'(done), 16'd0);
        chk("calc_prod", 16'(product), 16'(prev));
      end
    end
    start = 1'b0;
    chk("final_done", 16'(done), 16'd1);
    chk("final_prod", 16'(product), 16'(exp));
    prev = exp;
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    prev         = '0;
    repeat (2) @(negedge clk);
    chk("reset_done", 16'(done), 16'd0);
    chk("reset_prod", 16'(product), 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    mul(4'd11, 4'd14, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_done", 16'(done), 16'd1);
    chk("hold_prod", 16'(product), 16'd154);
    @(negedge clk);
    mul(4'd15, 4'd15, 1'b0);
    @(negedge clk);
    mul(4'd0, 4'd9, 1'b0);
    @(negedge clk);
    mul(4'd1, 4'd1, 1'b0);
    @(negedge clk);

    mul(4'd11, 4'd14, 1'b0);
    mul(4'd7, 4'd3, 1'b0);
    @(negedge clk);

    mul(4'd13, 4'd6, 1'b1);
    @(negedge clk);

    multiplicand = 4'd9;
    multiplier   = 4'd12;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_done", 16'(done), 16'd0);
    chk("midrst_prod", 16'(product), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev  = '0;
    repeat (6) @(posedge clk);
    #1;
    chk("postrst_done", 16'(done), 16'd0);
    chk("postrst_prod", 16'(product), 16'd0);
    @(negedge clk);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        mul(4'(a), 4'(b), 1'b0);
    @(negedge clk);

    for (int i = 0; i < 40; i++) begin
      mul(4'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
